// File: rtl/lane_deser_pkg.sv
// Shared constants and helpers for the lane deserializer.
package lane_deser_pkg;

  localparam int SLIP_CNT_W = 8;

  function automatic int cnt_width(input int dwidth);
    return $clog2(dwidth);
  endfunction

endpackage

// File: rtl/lane_deserializer_if.sv
// Serial-in / word-out bundle of one deserializer lane.
// Optional LANE_DESER_SLIP_COUNT_EN adds the slip_count status output.
interface lane_deserializer_if #(parameter int DWIDTH = 16);

  logic              data_in;
  logic              lane_polarity;
  logic              bit_slip;
  logic [DWIDTH-1:0] data_out;
  logic              data_valid;
`ifdef LANE_DESER_SLIP_COUNT_EN
  logic [lane_deser_pkg::SLIP_CNT_W-1:0] slip_count;

  modport master (output data_in, lane_polarity, bit_slip,
                  input  data_out, data_valid, slip_count);
  modport slave  (input  data_in, lane_polarity, bit_slip,
                  output data_out, data_valid, slip_count);
`else
  modport master (output data_in, lane_polarity, bit_slip,
                  input  data_out, data_valid);
  modport slave  (input  data_in, lane_polarity, bit_slip,
                  output data_out, data_valid);
`endif

endinterface

// File: rtl/lane_deser_edge_det.sv
// Rising-edge detector: one-cycle pulse on each 0->1 transition of the level input.
module lane_deser_edge_det (
  input  logic clk,
  input  logic res_n,
  input  logic i_level,
  output logic o_pulse
);

  logic r_level_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) r_level_q <= 1'b0;
    else        r_level_q <= i_level;
  end

  assign o_pulse = i_level & ~r_level_q;

endmodule

// File: rtl/lane_deserializer.sv
// Single-lane serial-to-parallel converter, LSB-first, with polarity and bit slip.
// Optional LANE_DESER_SLIP_COUNT_EN adds a saturating slip_count output.
module lane_deserializer
  import lane_deser_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input logic                 clk,
  input logic                 res_n,
  lane_deserializer_if.slave  bus
);

  localparam int              CW       = cnt_width(DWIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DWIDTH - 1);

  logic [DWIDTH-1:0] r_sreg;
  logic [CW-1:0]     r_cnt;
  logic [DWIDTH-1:0] r_data_out;
  logic              r_data_valid;
  logic              w_bit;
  logic              w_slip;
  logic [DWIDTH-1:0] w_next;

  lane_deser_edge_det u_slip_det (
    .clk     (clk),
    .res_n   (res_n),
    .i_level (bus.bit_slip),
    .o_pulse (w_slip)
  );

  assign w_bit  = bus.data_in ^ bus.lane_polarity;
  assign w_next = {w_bit, r_sreg[DWIDTH-1:1]};

  // A slip still shifts but freezes the counter, so the word boundary moves one bit later.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_sreg       <= '0;
      r_cnt        <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_sreg <= w_next;
      if (w_slip) begin
        r_data_valid <= 1'b0;
      end else if (r_cnt == CNT_LAST) begin
        r_data_out   <= w_next;
        r_data_valid <= 1'b1;
        r_cnt        <= '0;
      end else begin
        r_cnt        <= r_cnt + CW'(1);
        r_data_valid <= 1'b0;
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;

`ifdef LANE_DESER_SLIP_COUNT_EN
  logic [SLIP_CNT_W-1:0] r_slip_count;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)
      r_slip_count <= '0;
    else if (w_slip && (r_slip_count != {SLIP_CNT_W{1'b1}}))
      r_slip_count <= r_slip_count + SLIP_CNT_W'(1);
  end

  assign bus.slip_count = r_slip_count;
`endif

endmodule

// File: tb/tb_lane_deserializer.sv
// Randomized and directed bench for lane_deserializer against a sample-history model.
module tb_lane_deserializer;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic res_n;
  logic tb_rst_n;

  lane_deserializer_if #(.DWIDTH(DW)) bus ();

  lane_deserializer #(.DWIDTH(DW)) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: keep the last DW sampled bits; a word is due after DW non-slip samples since the last boundary.
  logic          m_q[$];
  int            m_pending;
  logic          m_slip_prev;
  logic          m_valid;
  logic [DW-1:0] m_dout;
  int            m_slips;

  function automatic void model_reset();
    m_q.delete();
    m_pending   = 0;
    m_slip_prev = 1'b0;
    m_valid     = 1'b0;
    m_dout      = '0;
    m_slips     = 0;
  endfunction

  function automatic void model_clock(input logic b, input logic slip_lvl);
    logic slip_ev;
    slip_ev     = slip_lvl && !m_slip_prev;
    m_slip_prev = slip_lvl;
    m_q.push_back(b);
    if (m_q.size() > DW) void'(m_q.pop_front());
    m_valid = 1'b0;
    if (slip_ev) begin
      if (m_slips < 255) m_slips++;
    end else begin
      m_pending++;
      if (m_pending == DW) begin
        for (int i = 0; i < DW; i++) m_dout[i] = m_q[i];
        m_valid   = 1'b1;
        m_pending = 0;
      end
    end
  endfunction

  logic [DW-1:0] seen_word;
  logic          last_valid;

  task automatic step(input logic din, input logic pol, input logic slip);
    @(negedge clk);
    bus.data_in       = din;
    bus.lane_polarity = pol;
    bus.bit_slip      = slip;
    res_n             = tb_rst_n;
    @(posedge clk);
    if (!tb_rst_n) model_reset();
    else           model_clock(din ^ pol, slip);
    #1;
    chk("data_valid", {31'd0, bus.data_valid}, {31'd0, m_valid});
    chk("data_out", {16'd0, bus.data_out}, {16'd0, m_dout});
`ifdef LANE_DESER_SLIP_COUNT_EN
    chk("slip_count", {24'd0, bus.slip_count}, m_slips);
`endif
    last_valid = bus.data_valid;
    if (bus.data_valid) seen_word = bus.data_out;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input logic [DW-1:0] polmask);
    for (int i = 0; i < DW; i++) step(w[i], polmask[i], 1'b0);
  endtask

  logic [DW-1:0] pat_word;
  int            pat_idx;

  task automatic pat(input int n, input logic slip);
    repeat (n) begin
      step(pat_word[pat_idx % DW], 1'b0, slip);
      pat_idx++;
    end
  endtask

  task automatic do_reset();
    tb_rst_n = 1'b0;
    repeat (2) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    tb_rst_n = 1'b1;
    pat_idx  = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [DW-1:0] w;
    logic lvl;
    bus.data_in = 1'b0; bus.lane_polarity = 1'b0; bus.bit_slip = 1'b0;
    res_n = 1'b0; tb_rst_n = 1'b0;
    seen_word = '0; last_valid = 1'b0; pat_idx = 0;
    model_reset();

    // Reset held with serial activity: outputs must stay clear.
    repeat (4) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      chk("rst_dout", {16'd0, bus.data_out}, 32'd0);
    end

    // First word latency and LSB-first ordering.
    w = 16'hA5C3;
    tb_rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(w[i % DW], 1'b0, 1'b0);
      n++;
      if (last_valid) break;
    end
    chk("first_valid_lat", n, 16);
    chk("first_word", {16'd0, seen_word}, 32'h0000A5C3);

    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(w[i % DW], 1'b0, 1'b0);
      n++;
      if (last_valid) break;
    end
    chk("valid_period", n, 16);

    send_word(16'hA5C3, 16'hFFFF);
    chk("pol_valid", {31'd0, last_valid}, 32'd1);
    chk("pol_word", {16'd0, seen_word}, 32'h00005A3C);
    send_word(16'hA5C3, 16'hFF00);
    chk("pol_toggle_word", {16'd0, seen_word}, 32'h00005AC3);

    // Bit slip on a repeating 0x0001 pattern.
    pat_word = 16'h0001;
    do_reset();
    pat(32, 1'b0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(pat_word[pat_idx % DW], 1'b0, i == 0);
      pat_idx++;
      n++;
      if (last_valid) break;
    end
    chk("slip_span", n, 17);
    pat(32, 1'b0);
    chk("slip1_word", {16'd0, seen_word}, 32'h00008000);
    for (int k = 0; k < 15; k++) begin
      pat(1, 1'b1);
      pat(1, 1'b0);
    end
    pat(48, 1'b0);
    chk("slip16_word", {16'd0, seen_word}, 32'h00000001);
    pat(5, 1'b1);
    pat(40, 1'b0);
    chk("slip_hold_word", {16'd0, seen_word}, 32'h00008000);

    // Slip coinciding with the last bit of a word.
    do_reset();
    pat(15, 1'b0);
    pat(1, 1'b1);
    chk("bnd_no_valid", {31'd0, last_valid}, 32'd0);
    pat(1, 1'b0);
    chk("bnd_valid", {31'd0, last_valid}, 32'd1);

    // Asynchronous reset mid-word.
    pat(30, 1'b0);
    pat(7, 1'b0);
    #2;
    res_n = 1'b0; tb_rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_dout", {16'd0, bus.data_out}, 32'd0);
    chk("async_valid", {31'd0, bus.data_valid}, 32'd0);
    step(1'b1, 1'b0, 1'b0);
    tb_rst_n = 1'b1;
    send_word(16'h1234, 16'h0000);
    chk("post_rst_valid", {31'd0, last_valid}, 32'd1);
    chk("post_rst_word", {16'd0, seen_word}, 32'h00001234);

    // Randomized traffic with occasional slips and resets.
    lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) lvl = ~lvl;
      tb_rst_n = ($urandom_range(0, 499) != 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), lvl);
    end
    tb_rst_n = 1'b1;

`ifdef LANE_DESER_SLIP_COUNT_EN
    do_reset();
    for (int k = 0; k < 300; k++) begin
      pat(1, 1'b1);
      pat(1, 1'b0);
    end
    chk("slip_count_sat", {24'd0, bus.slip_count}, 32'd255);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
